// File: rtl/axi_resp_pkg.sv
// Shared constants and state type for AXI read/write responders.
// Burst encodings, response codes and the responder FSM state enum.
package axi_resp_pkg;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } resp_state_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Next beat address for FIXED/INCR/WRAP bursts and WRAP legality check.
// Purely combinational so both read and write responders can share it.
module axi_burst_addr
  import axi_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  wrap_ok
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_bytes;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic                  len_ok;
  logic                  aligned;

  always_comb begin
    step       = ADDR_WIDTH'(1) << size;
    incr_addr  = addr + step;
    wrap_bytes = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    wrap_mask  = wrap_bytes - ADDR_WIDTH'(1);

    // Reserved burst type keeps the address constant; the beat errors anyway.
    case (burst)
      FIXED:   next_addr = addr;
      INCR:    next_addr = incr_addr;
      WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = addr;
    endcase

    len_ok  = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    aligned = ((addr & (step - ADDR_WIDTH'(1))) == '0);
    wrap_ok = (burst != WRAP) || (len_ok && aligned);
  end

endmodule

// File: rtl/axi_read_responder.sv
// AXI4 read-channel responder backed by a 64-bit word array with a side loader.
// One outstanding burst; rdata/rresp/rlast are registered, one beat per cycle.
module axi_read_responder
  import axi_resp_pkg::*;
#(
  parameter int              ID_WIDTH   = 13,
  parameter int              ADDR_WIDTH = 64,
  parameter int              DATA_WIDTH = 64,
  parameter int              DEPTH      = 4096,
  parameter logic [63:0]     BASE_ADDR  = 64'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ID_WIDTH-1:0]      s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
  input  logic [7:0]               s_axi_arlen,
  input  logic [2:0]               s_axi_arsize,
  input  logic [1:0]               s_axi_arburst,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [ID_WIDTH-1:0]      s_axi_rid,
  output logic [DATA_WIDTH-1:0]    s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rlast,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  output resp_state_e              fsm_state
);

  localparam int                    IDXW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH) << 3;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and payload holds while valid && !ready.

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  resp_state_e           state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  err_q;
  logic [7:0]            beat_cnt;

  logic                  idle;
  logic                  ar_hs;
  logic                  r_hs;
  logic [ADDR_WIDTH-1:0] ba_addr;
  logic [7:0]            ba_len;
  logic [2:0]            ba_size;
  logic [1:0]            ba_burst;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  wrap_ok;

  logic                  load;
  logic                  beat_last;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_range;
  logic                  beat_fatal;
  logic                  beat_err;
  logic [IDXW-1:0]       beat_idx;
  logic [DATA_WIDTH-1:0] beat_word;

  assign fsm_state = state;
  assign idle      = (state == ST_IDLE);
  assign ar_hs     = s_axi_arvalid && s_axi_arready;
  assign r_hs      = s_axi_rvalid && s_axi_rready;

  // In IDLE the helper judges the incoming AR; in BURST it steps the beat.
  assign ba_addr  = idle ? s_axi_araddr  : addr_q;
  assign ba_len   = idle ? s_axi_arlen   : len_q;
  assign ba_size  = idle ? s_axi_arsize  : size_q;
  assign ba_burst = idle ? s_axi_arburst : burst_q;

  axi_burst_addr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_burst_addr (
    .addr      (ba_addr),
    .len       (ba_len),
    .size      (ba_size),
    .burst     (ba_burst),
    .next_addr (next_addr),
    .wrap_ok   (wrap_ok)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    beat_last  = 1'b0;
    beat_addr  = addr_q;
    case (state)
      ST_IDLE: begin
        if (ar_hs) begin
          state_next = ST_BURST;
          load       = 1'b1;
          beat_addr  = s_axi_araddr;
          beat_last  = (s_axi_arlen == 8'd0);
        end
      end
      ST_BURST: begin
        if (r_hs) begin
          if (s_axi_rlast) begin
            state_next = ST_IDLE;
          end else begin
            load      = 1'b1;
            beat_addr = next_addr;
            beat_last = (8'(beat_cnt + 8'd1) == len_q);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Per-beat error and word fetch for the beat about to be registered.
  always_comb begin
    offset     = beat_addr - BASE;
    in_range   = (beat_addr >= BASE) && (offset < SPAN);
    beat_fatal = idle ? !wrap_ok : err_q;
    beat_err   = !in_range || (ba_size > 3'd3) || (ba_burst == 2'b11) || beat_fatal;
    beat_idx   = IDXW'(offset >> 3);
    beat_word  = mem[beat_idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= OKAY;
      s_axi_rlast   <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      size_q        <= '0;
      burst_q       <= FIXED;
      err_q         <= 1'b0;
      beat_cnt      <= '0;
    end else begin
      state         <= state_next;
      s_axi_arready <= (state_next == ST_IDLE);
      s_axi_rvalid  <= (state_next == ST_BURST);
      if (idle && ar_hs) begin
        s_axi_rid <= s_axi_arid;
        addr_q    <= s_axi_araddr;
        len_q     <= s_axi_arlen;
        size_q    <= s_axi_arsize;
        burst_q   <= s_axi_arburst;
        err_q     <= !wrap_ok;
        beat_cnt  <= '0;
      end else if (load) begin
        addr_q   <= next_addr;
        beat_cnt <= 8'(beat_cnt + 8'd1);
      end
      if (load) begin
        s_axi_rdata <= beat_err ? '0 : beat_word;
        s_axi_rresp <= beat_err ? SLVERR : OKAY;
        s_axi_rlast <= beat_last;
      end
    end
  end

  // The array is deliberately not reset; loader writes land after the read.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder: wrap fetch, stalls, errors, reset, loader.
module tb_axi_read_responder;
  import axi_resp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] arid = '0;
  logic [63:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [12:0] rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        ld_en = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [63:0] ld_data = '0;
  resp_state_e fsm_state;

  int          n_tests = 0;
  int          n_fail = 0;
  int          waited;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  axi_read_responder dut (
    .clk           (clk),
    .reset         (rst_n),
    .s_axi_arid    (arid),
    .s_axi_araddr  (araddr),
    .s_axi_arlen   (arlen),
    .s_axi_arsize  (arsize),
    .s_axi_arburst (arburst),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rid     (rid),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rlast   (rlast),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .ld_en         (ld_en),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .fsm_state     (fsm_state)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_ar(input logic [12:0] id, input logic [63:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst, output int wait_cyc);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    wait_cyc = 0;
    while (!arready && wait_cyc < 20) begin
      tick();
      wait_cyc++;
    end
    check("ar_accept", 64'(arready), 64'd1);
    tick();
    arvalid = 1'b0;
    check("rvalid_after_ar", 64'(rvalid), 64'd1);
    check("arready_in_burst", 64'(arready), 64'd0);
  endtask

  // Drains n beats from exp_q; stall inserts rready 1,0,0 pattern; ld_beat>0 writes
  // 0x44 to word ld_beat on the edge that registers beat ld_beat.
  task automatic collect(input int n, input int last_beat, input logic [12:0] exp_id,
                         input logic [1:0] exp_resp, input bit stall, input int ld_beat);
    int          beats = 0;
    int          cyc = 0;
    logic        snap_v = 1'b0;
    logic [63:0] snap_d = '0;
    logic        snap_l = 1'b0;
    logic [1:0]  snap_r = '0;
    logic [63:0] exp;
    while (beats < n && cyc < 100) begin
      if (snap_v) begin
        check("stall_rdata", rdata, snap_d);
        check("stall_rlast", 64'(rlast), 64'(snap_l));
        check("stall_rresp", 64'(rresp), 64'(snap_r));
        snap_v = 1'b0;
      end
      rready = stall ? (cyc % 3 == 0) : 1'b1;
      ld_en  = 1'b0;
      if (rvalid && rready) begin
        exp = exp_q.pop_front();
        check("rdata", rdata, exp);
        check("rresp", 64'(rresp), 64'(exp_resp));
        check("rlast", 64'(rlast), 64'(beats == last_beat));
        check("rid", 64'(rid), 64'(exp_id));
        if (beats == ld_beat - 1) begin
          ld_en = 1'b1; ld_addr = 12'(ld_beat); ld_data = 64'h44;
        end
        beats++;
      end else if (rvalid) begin
        snap_v = 1'b1; snap_d = rdata; snap_l = rlast; snap_r = rresp;
      end
      tick();
      cyc++;
    end
    rready = 1'b0;
    ld_en  = 1'b0;
    check("beat_count", 64'(beats), 64'(n));
    if (n == last_beat + 1) begin
      check("rvalid_done", 64'(rvalid), 64'd0);
      check("arready_done", 64'(arready), 64'd1);
    end
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    check("rst_rresp", 64'(rresp), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_rid", 64'(rid), 64'd0);
    check("rst_state", 64'(fsm_state), 64'(ST_IDLE));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("arready_after_release", 64'(arready), 64'd1);

    for (int i = 0; i < 32; i++) begin
      ld_en = 1'b1; ld_addr = 12'(i); ld_data = 64'(i);
      tick();
    end
    ld_en = 1'b0;
    tick();

    // Fetch-style WRAP
    exp_q = '{64'd3, 64'd3, 64'd0, 64'd0, 64'd1, 64'd1, 64'd2, 64'd2};
    do_ar(13'h5, 64'h18, 8'd7, 3'd2, WRAP, waited);
    collect(8, 7, 13'h5, OKAY, 1'b0, -1);

    // INCR with backpressure
    exp_q = '{64'd8, 64'd9, 64'd10, 64'd11};
    do_ar(13'h1abc, 64'h40, 8'd3, 3'd3, INCR, waited);
    collect(4, 3, 13'h1abc, OKAY, 1'b1, -1);

    // FIXED
    exp_q = '{64'd9, 64'd9};
    do_ar(13'h2, 64'h48, 8'd1, 3'd3, FIXED, waited);
    collect(2, 1, 13'h2, OKAY, 1'b0, -1);

    // Out of range
    exp_q = '{64'd0, 64'd0};
    do_ar(13'h7, 64'h8000, 8'd1, 3'd3, INCR, waited);
    collect(2, 1, 13'h7, SLVERR, 1'b0, -1);

    // Illegal WRAP length, then back-to-back AR
    exp_q = '{64'd0, 64'd0, 64'd0};
    do_ar(13'h9, 64'h0, 8'd2, 3'd3, WRAP, waited);
    collect(3, 2, 13'h9, SLVERR, 1'b0, -1);
    exp_q = '{64'd5};
    do_ar(13'ha, 64'h28, 8'd0, 3'd3, INCR, waited);
    check("ar_gap", 64'(waited), 64'd0);
    collect(1, 0, 13'ha, OKAY, 1'b0, -1);

    // Reset mid-burst
    exp_q = '{64'd0, 64'd1, 64'd2};
    do_ar(13'h3, 64'h0, 8'd7, 3'd3, INCR, waited);
    collect(3, 7, 13'h3, OKAY, 1'b0, -1);
    rst_n = 1'b0;
    #1;
    check("midrst_rvalid", 64'(rvalid), 64'd0);
    check("midrst_arready", 64'(arready), 64'd0);
    check("midrst_rdata", rdata, 64'd0);
    check("midrst_rid", 64'(rid), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_arready_release", 64'(arready), 64'd1);
    check("midrst_no_beats", 64'(rvalid), 64'd0);
    exp_q = '{64'd6};
    do_ar(13'h4, 64'h30, 8'd0, 3'd3, INCR, waited);
    collect(1, 0, 13'h4, OKAY, 1'b0, -1);

    // Loader collision: old value, then new value on rerun
    exp_q = '{64'd0, 64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7};
    do_ar(13'h1, 64'h0, 8'd7, 3'd3, INCR, waited);
    collect(8, 7, 13'h1, OKAY, 1'b0, 4);
    exp_q = '{64'd0, 64'd1, 64'd2, 64'd3, 64'h44, 64'd5, 64'd6, 64'd7};
    do_ar(13'h1, 64'h0, 8'd7, 3'd3, INCR, waited);
    collect(8, 7, 13'h1, OKAY, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_read_responder.md
# axi_read_responder

AXI4 read-channel responder: the memory end of the AR/R interface that the core's instruction-fetch master drives. It accepts one read address at a time and returns FIXED, INCR or WRAP bursts from an internal 64-bit-wide memory array. It sits on the bus side as the fetch/bench memory model. A side loader port preloads program images.

## Interface
- ID_WIDTH, 13: AXI ID width.
- ADDR_WIDTH, 64: address width.
- DATA_WIDTH, 64: data width. Fixed at 64.
- DEPTH, 4096: number of 64-bit words in the array.
- BASE_ADDR, 64'h0: byte address of word 0.
- clk  in  1  Single clock for the block.
- reset  in  1  Asynchronous, active-low reset.
- s_axi_arid  in  ID_WIDTH  Read ID.
- s_axi_araddr  in  ADDR_WIDTH  Byte address of the first beat.
- s_axi_arlen  in  8  Beats minus 1.
- s_axi_arsize  in  3  Bytes per beat, encoded as log2. Legal values 0..3.
- s_axi_arburst  in  2  Burst type: FIXED, INCR or WRAP.
- s_axi_arvalid  in  1  / s_axi_arready  out  1  AR handshake.
- s_axi_rid  out  ID_WIDTH  Echo of the latched arid.
- s_axi_rdata  out  64  Full aligned word containing the beat address.
- s_axi_rresp  out  2  OKAY (00) or SLVERR (10).
- s_axi_rlast  out  1  Marks the final beat.
- s_axi_rvalid  out  1  / s_axi_rready  in  1  R handshake.
- ld_en  in  1  Loader write strobe.
- ld_addr  in  $clog2(DEPTH)  Loader word index.
- ld_data  in  64  Loader write data.

## Operation
- FSM states:
  - IDLE: arready=1.
  - BURST: arready=0, rvalid=1.
- IDLE→BURST on arvalid&&arready. On that edge the block latches id, addr, len, size and burst, and sets beat count=0.
- BURST→IDLE on rvalid&&rready&&rlast.
- Beat address:
  - FIXED: constant.
  - INCR: addr + (1<<size).
  - WRAP:
    - wrap_bytes = (len+1)<<size.
    - next = (addr & ~(wrap_bytes-1)) | ((addr + (1<<size)) & (wrap_bytes-1)).
  - All arithmetic is ADDR_WIDTH bits; INCR wrap-around at 2^64 is ignored.
- Word select: idx = (addr − BASE_ADDR)>>3. rdata is the whole word; narrow beats rely on the byte-lane position.
- SLVERR conditions, applied per beat with rdata=0:
  - addr < BASE_ADDR, or addr ≥ BASE_ADDR+DEPTH*8;
  - size > 3;
  - burst==2'b11 (reserved).
- SLVERR conditions, applied to every beat of the burst, decided at AR acceptance:
  - WRAP with len not in {1,3,7,15};
  - WRAP with addr not aligned to 1<<size.
- Beat count always ends at exactly len+1 beats, including error bursts.
- Loader: on ld_en, array[ld_addr] is written at the clock edge. The loader is legal in any state. A beat registered on the same edge reads the old word (read-before-write).

## Timing
- Reset asserted: all outputs are 0 immediately (arready, rvalid, rlast, rresp, rdata, rid) and the FSM goes to IDLE. A burst in flight is abandoned with no further beats. Array contents are not reset.
- First rising edge after reset release: arready=1.
- Latency: rvalid=1 with beat 0 on the cycle after the AR handshake.
- Throughput: one beat per cycle while rready=1.
- Backpressure: while rvalid&&!rready, rdata, rresp, rlast and rid hold stable.
- rlast=1 exactly on beat len.
- After the last R handshake, arready=1 on the next cycle. Minimum gap between AR handshakes is len+2 cycles.
- Outstanding transactions: one. arvalid during BURST is not accepted.

## Structure
- Package axi_resp_pkg holds:
  - burst constants FIXED=2'b00, INCR=2'b01, WRAP=2'b10;
  - response constants OKAY=2'b00, SLVERR=2'b10;
  - the responder state enum.
- Sub-module axi_burst_addr: combinational next-address and WRAP-legality function of (addr, len, size, burst). It is shared with future write responders.
- rdata, rresp and rlast are registered outputs. The array is read through the registered next-beat address.

## Test plan
- Fetch-style wrap: array[i]=i, araddr=BASE+0x18, size=2, len=7, WRAP, arid=0x5 → 8 beats at byte addrs 0x18,0x1C,0x00,0x04,0x08,0x0C,0x10,0x14; word indices 3,3,0,0,1,1,2,2; rid=0x5; OKAY; rlast on beat 7 only.
- INCR, size=3, len=3, araddr=BASE+0x40, with rready toggled 1,0,0,1,… → rdata 8,9,10,11. Outputs are stable during stalls. Exactly 4 handshakes.
- Out-of-range araddr=BASE+DEPTH*8, INCR, len=1 → 2 beats, rresp=10, rdata=0, rlast on beat 1.
- WRAP with len=2 → 3 beats, all SLVERR. Next AR accepted one cycle after the last handshake.
- Reset asserted after beat 2 of a len=7 burst → rvalid=0 immediately. arready=1 after release. A new INCR len=0 burst returns the correct word.
- Loader write to word 4 on the same edge that beat 4 is registered → beat shows the old value. A rerun of the burst shows the new value.
